// File: rtl/collector_pkg.sv
// Shared definitions for the output-buffer collector.
//   DATA_WIDTH_DEF : default systolic-array element width (results are 2x wide)
//   NUM_CH         : number of output buffers feeding the collector
//   ST_*           : collector FSM state encoding
//   next_ptr       : round-robin pointer advance, modulo NUM_CH
package collector_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int NUM_CH         = 3;

    localparam logic [1:0] ST_SEL  = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    function automatic logic [1:0] next_ptr(input logic [1:0] ch);
        return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
    endfunction

endpackage

// File: rtl/obf_collector_if.sv
// Bus between three output buffers, the collector and the downstream sink.
//   obfN_empty/err/out : buffer status and read data (data is signed)
//   obfN_rd_en         : buffer read strobes (data follows one cycle later)
//   out_*              : serialized result stream with valid/ready handshake
//   frame_done/err_any : frame-end pulse and sticky error
// modport slave is the collector's view; master is the surrounding system.
interface obf_collector_if #(
    parameter int DATA_WIDTH = collector_pkg::DATA_WIDTH_DEF
) ();

    logic                           obf0_empty, obf1_empty, obf2_empty;
    logic                           obf0_err,   obf1_err,   obf2_err;
    logic signed [2*DATA_WIDTH-1:0] obf0_out,   obf1_out,   obf2_out;
    logic                           obf0_rd_en, obf1_rd_en, obf2_rd_en;
    logic        [2*DATA_WIDTH-1:0] out_data;
    logic        [1:0]              out_ch;
    logic                           out_valid;
    logic                           out_ready;
    logic                           frame_done;
    logic                           err_any;

    modport slave (
        input  obf0_empty, obf1_empty, obf2_empty,
        input  obf0_err,   obf1_err,   obf2_err,
        input  obf0_out,   obf1_out,   obf2_out,
        input  out_ready,
        output obf0_rd_en, obf1_rd_en, obf2_rd_en,
        output out_data, out_ch, out_valid, frame_done, err_any
    );

    modport master (
        output obf0_empty, obf1_empty, obf2_empty,
        output obf0_err,   obf1_err,   obf2_err,
        output obf0_out,   obf1_out,   obf2_out,
        output out_ready,
        input  obf0_rd_en, obf1_rd_en, obf2_rd_en,
        input  out_data, out_ch, out_valid, frame_done, err_any
    );

endinterface

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter, purely combinational.
//   request : one bit per buffer, high when that buffer has data
//   ptr     : highest-priority index for this search (0..2)
//   grant   : one-hot winner, all zero when nothing is requested
//   found   : any request granted
module rr_arb3
    import collector_pkg::*;
(
    input  logic [2:0] request,
    input  logic [1:0] ptr,
    output logic [2:0] grant,
    output logic       found
);

    localparam int unsigned NCH = NUM_CH;

    int unsigned idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = (32'(ptr) + i) % NCH;
            if (!found && request[idx[1:0]]) begin
                grant[idx[1:0]] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/obf_collector.sv
// Collects results from three output buffers and serializes them onto one
// valid/ready stream, tagging each with its source buffer index.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : obf_collector_if.slave (buffer side + output stream)
// Parameters: DATA_WIDTH (element width, results 2x), OUT_NUM (results per
// frame), RELU_EN (clamp negative results to zero).
module obf_collector
    import collector_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OUT_NUM    = 27,
    parameter int RELU_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    obf_collector_if.slave        bus
);

    localparam int RW    = 2 * DATA_WIDTH;
    localparam int CNT_W = $clog2(OUT_NUM + 1);

    logic [1:0]       state_q,    state_d;
    logic [1:0]       ptr_q,      ptr_d;
    logic [1:0]       sel_q,      sel_d;
    logic [1:0]       out_ch_q,   out_ch_d;
    logic [RW-1:0]    out_data_q, out_data_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             err_q,      err_d;

    logic [2:0]       request;
    logic [2:0]       grant;
    logic             found;
    logic [2:0]       rd_en;
    logic             frame_done;
    logic [RW-1:0]    raw_data;
    logic [RW-1:0]    relu_data;

    assign request = ~{bus.obf2_empty, bus.obf1_empty, bus.obf0_empty};

    rr_arb3 u_arb (
        .request (request),
        .ptr     (ptr_q),
        .grant   (grant),
        .found   (found)
    );

    // Read data arrives one cycle after the strobe, so it is taken in LOAD
    // from the buffer remembered in sel_q.
    always_comb begin
        case (sel_q)
            2'd0:    raw_data = bus.obf0_out;
            2'd1:    raw_data = bus.obf1_out;
            default: raw_data = bus.obf2_out;
        endcase
        relu_data = ((RELU_EN != 0) && raw_data[RW-1]) ? '0 : raw_data;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        out_ch_d   = out_ch_q;
        out_data_d = out_data_q;
        cnt_d      = cnt_q;
        rd_en      = '0;
        frame_done = 1'b0;
        err_d      = err_q | bus.obf0_err | bus.obf1_err | bus.obf2_err;

        case (state_q)
            ST_SEL: begin
                // rst_n gate keeps strobes low while reset is held
                if (found && rst_n) begin
                    rd_en   = grant;
                    sel_d   = grant[1] ? 2'd1 : (grant[2] ? 2'd2 : 2'd0);
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                out_data_d = relu_data;
                out_ch_d   = sel_q;
                ptr_d      = next_ptr(sel_q);
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (bus.out_ready) begin
                    state_d = ST_SEL;
                    if (cnt_q == CNT_W'(OUT_NUM - 1)) begin
                        cnt_d      = '0;
                        frame_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_SEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SEL;
            ptr_q      <= '0;
            sel_q      <= '0;
            out_ch_q   <= '0;
            out_data_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            out_ch_q   <= out_ch_d;
            out_data_q <= out_data_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.obf0_rd_en = rd_en[0];
    assign bus.obf1_rd_en = rd_en[1];
    assign bus.obf2_rd_en = rd_en[2];
    assign bus.out_data   = out_data_q;
    assign bus.out_ch     = out_ch_q;
    assign bus.out_valid  = (state_q == ST_SEND);
    assign bus.frame_done = frame_done;
    assign bus.err_any    = err_q;

endmodule

// File: tb/tb_obf_collector.sv
// Directed bench for obf_collector with queue-based buffer models and a
// scoreboard of expected results in expected output order.
module tb_obf_collector;

    localparam int DW      = 8;
    localparam int RW      = 2 * DW;
    localparam int OUT_NUM = 27;

    typedef struct {
        logic [RW-1:0] d;
        logic [1:0]    ch;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    obf_collector_if #(.DATA_WIDTH(DW)) bus  ();
    obf_collector_if #(.DATA_WIDTH(DW)) busn ();

    obf_collector #(.DATA_WIDTH(DW), .OUT_NUM(OUT_NUM), .RELU_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    obf_collector #(.DATA_WIDTH(DW), .OUT_NUM(OUT_NUM), .RELU_EN(0)) dut_nr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busn)
    );

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] q0[$], q1[$], q2[$];
    exp_t          sb[$];
    logic [2:0]    rd_s = '0;
    int unsigned   cyc = 0;
    int unsigned   xfer_t[$];
    int            xfer_cnt = 0;
    int            fd_pulses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_buf(input int ch, input logic [RW-1:0] v);
        case (ch)
            0: begin q0.push_back(v); bus.obf0_empty = 1'b0; end
            1: begin q1.push_back(v); bus.obf1_empty = 1'b0; end
            default: begin q2.push_back(v); bus.obf2_empty = 1'b0; end
        endcase
    endtask

    task automatic expect_out(input int ch, input logic [RW-1:0] v);
        exp_t e;
        e.d  = v[RW-1] ? '0 : v;   // ReLU enabled on the main instance
        e.ch = 2'(ch);
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!bus.out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.out_valid, 1);
    endtask

    // Buffer model: data appears on obfN_out on the edge after the strobe.
    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (rd_s[0] && q0.size() > 0) bus.obf0_out = q0.pop_front();
            if (rd_s[1] && q1.size() > 0) bus.obf1_out = q1.pop_front();
            if (rd_s[2] && q2.size() > 0) bus.obf2_out = q2.pop_front();
            bus.obf0_empty = (q0.size() == 0);
            bus.obf1_empty = (q1.size() == 0);
            bus.obf2_empty = (q2.size() == 0);
        end
    end

    // Monitor: strobe legality, scoreboard compare, frame_done model.
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_s     = '0;
            xfer_cnt = 0;
        end else begin
            exp_t e;
            logic fd_exp;
            rd_s = {bus.obf2_rd_en, bus.obf1_rd_en, bus.obf0_rd_en};
            check("rd_onehot", ($countones(rd_s) <= 1), 1);
            check("rd_on_empty", |(rd_s & {bus.obf2_empty, bus.obf1_empty, bus.obf0_empty}), 0);
            check("rd_outside_sel", (|rd_s) && bus.out_valid, 0);
            if (bus.out_valid && bus.out_ready) begin
                check("sb_nonempty", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_data", bus.out_data, e.d);
                    check("out_ch", bus.out_ch, e.ch);
                end
                fd_exp = (xfer_cnt == OUT_NUM - 1);
                check("frame_done_xfer", bus.frame_done, fd_exp);
                xfer_cnt = fd_exp ? 0 : xfer_cnt + 1;
                if (bus.frame_done) fd_pulses++;
                xfer_t.push_back(cyc);
            end else begin
                check("frame_done_idle", bus.frame_done, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int seen;
        logic [RW-1:0] held;

        bus.obf0_empty = 1'b1; bus.obf1_empty = 1'b1; bus.obf2_empty = 1'b1;
        bus.obf0_err = 1'b0;   bus.obf1_err = 1'b0;   bus.obf2_err = 1'b0;
        bus.obf0_out = '0;     bus.obf1_out = '0;     bus.obf2_out = '0;
        bus.out_ready = 1'b1;
        busn.obf0_empty = 1'b1; busn.obf1_empty = 1'b1; busn.obf2_empty = 1'b1;
        busn.obf0_err = 1'b0;   busn.obf1_err = 1'b0;   busn.obf2_err = 1'b0;
        busn.obf0_out = '0;     busn.obf1_out = '0;     busn.obf2_out = '0;
        busn.out_ready = 1'b1;

        // Reset values
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_ch", bus.out_ch, 0);
        check("rst_err", bus.err_any, 0);
        check("rst_frame", bus.frame_done, 0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Round-robin order with all three buffers loaded, 3-cycle spacing
        n0 = xfer_t.size();
        push_buf(0, 16'd5); push_buf(1, 16'd6); push_buf(2, 16'd7);
        expect_out(0, 16'd5); expect_out(1, 16'd6); expect_out(2, 16'd7);
        wait_drain("rr_drain", 40);
        check("rr_count", xfer_t.size() - n0, 3);
        if (xfer_t.size() >= n0 + 3) begin
            check("rr_space1", xfer_t[n0 + 1] - xfer_t[n0], 3);
            check("rr_space2", xfer_t[n0 + 2] - xfer_t[n0 + 1], 3);
        end

        // Pointer back at 0: ch0 wins over ch2, then ch2
        step();
        push_buf(2, 16'h0022); push_buf(0, 16'h0011);
        expect_out(0, 16'h0011); expect_out(2, 16'h0022);
        wait_drain("ptr0_drain", 40);

        // Single buffer: strobe one cycle, valid two cycles later
        step();
        push_buf(1, 16'h0123);
        expect_out(1, 16'h0123);
        @(negedge clk);
        check("lat_rd1", bus.obf1_rd_en, 1);
        check("lat_rd0", bus.obf0_rd_en, 0);
        check("lat_rd2", bus.obf2_rd_en, 0);
        @(negedge clk);
        check("lat_rd1_low", bus.obf1_rd_en, 0);
        check("lat_valid_load", bus.out_valid, 0);
        @(negedge clk);
        check("lat_valid", bus.out_valid, 1);
        check("lat_data", bus.out_data, 16'h0123);
        check("lat_ch", bus.out_ch, 1);
        wait_drain("lat_drain", 20);

        // ReLU on main instance, pass-through on RELU_EN=0 instance
        step();
        push_buf(0, 16'hFFF0);
        expect_out(0, 16'hFFF0);
        busn.obf0_out = 16'hFFF0;
        busn.obf0_empty = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (busn.obf0_rd_en) seen = 1;
        end
        check("nr_rd_seen", seen, 1);
        step();
        busn.obf0_empty = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (busn.out_valid) seen = 1;
        end
        check("nr_valid_seen", seen, 1);
        check("nr_data", busn.out_data, 16'hFFF0);
        check("nr_ch", busn.out_ch, 0);
        wait_drain("relu_drain", 20);

        // Backpressure: 10 cycles held in SEND, no strobes, one transfer after
        bus.out_ready = 1'b0;
        step();
        push_buf(2, 16'h0042);
        expect_out(2, 16'h0042);
        wait_valid("stall_valid", 20);
        held = bus.out_data;
        check("stall_data0", held, 16'h0042);
        step();
        push_buf(0, 16'h0055); push_buf(1, 16'h0066);
        expect_out(0, 16'h0055); expect_out(1, 16'h0066);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid_hold", bus.out_valid, 1);
            check("stall_data_hold", bus.out_data, held);
            check("stall_ch_hold", bus.out_ch, 2);
            check("stall_no_rd", {bus.obf2_rd_en, bus.obf1_rd_en, bus.obf0_rd_en}, 0);
        end
        n0 = xfer_t.size();
        step();
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stall_one_xfer", xfer_t.size() - n0, 1);
        wait_drain("stall_drain", 40);

        // Full frame from a clean reset: frame_done exactly once on the 27th
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        n0 = fd_pulses;
        for (int i = 0; i < 9; i++) begin
            push_buf(0, 16'h0100 + 16'(i));
            push_buf(1, 16'h0200 + 16'(i));
            push_buf(2, 16'h8300 + 16'(i));
        end
        for (int i = 0; i < 9; i++) begin
            expect_out(0, 16'h0100 + 16'(i));
            expect_out(1, 16'h0200 + 16'(i));
            expect_out(2, 16'h8300 + 16'(i));
        end
        wait_drain("frame_drain", 200);
        check("frame_pulses", fd_pulses - n0, 1);
        // Counter restarted: a further result must not raise frame_done
        step();
        push_buf(1, 16'h0033);
        expect_out(1, 16'h0033);
        wait_drain("post_frame_drain", 20);
        check("post_frame_pulses", fd_pulses - n0, 1);

        // Sticky error, then asynchronous reset in the middle of SEND
        step();
        bus.obf2_err = 1'b1;
        step();
        bus.obf2_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("err_sticky", bus.err_any, 1);
        end
        bus.out_ready = 1'b0;
        step();
        push_buf(1, 16'h0077);
        wait_valid("mid_send_valid", 20);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", bus.out_valid, 0);
        check("arst_data", bus.out_data, 0);
        check("arst_ch", bus.out_ch, 0);
        check("arst_err", bus.err_any, 0);
        check("arst_frame", bus.frame_done, 0);
        check("arst_rd", {bus.obf2_rd_en, bus.obf1_rd_en, bus.obf0_rd_en}, 0);
        sb.delete();
        q0.delete(); q1.delete(); q2.delete();
        bus.obf0_empty = 1'b1; bus.obf1_empty = 1'b1; bus.obf2_empty = 1'b1;
        step();
        step();
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        step();
        check("post_rst_err", bus.err_any, 0);
        push_buf(0, 16'h0099);
        expect_out(0, 16'h0099);
        wait_drain("post_rst_drain", 20);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obf_collector.md
OBF_COLLECTOR -- requirements
Module: obf_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the systolic-array input element width; result width is 2*DATA_WIDTH.
REQ-002 Parameter OUT_NUM, default 27, is the results per frame across all three buffers.
REQ-003 Parameter RELU_EN, default 1, enables ReLU on emitted results.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 obf0_empty, obf1_empty, obf2_empty  in  1 each  output-buffer empty flags.
REQ-007 obf0_err, obf1_err, obf2_err  in  1 each  output-buffer error flags.
REQ-008 obf0_out, obf1_out, obf2_out  in  2*DATA_WIDTH each  buffer read data, signed.
REQ-009 obf0_rd_en, obf1_rd_en, obf2_rd_en  out  1 each  buffer read strobes.
REQ-010 out_data  out  2*DATA_WIDTH  serialized result.
REQ-011 out_ch  out  2  source buffer index, 0..2.
REQ-012 out_valid  out  1  out_data/out_ch valid.
REQ-013 out_ready  in  1  downstream accept.
REQ-014 frame_done  out  1  one-cycle pulse on the last result of a frame.
REQ-015 err_any  out  1  sticky error.

Function
REQ-016 Buffer read latency SHALL be one cycle: obfN_out is sampled on the clk edge after the edge where obfN_rd_en was high.
REQ-017 FSM states SHALL be SEL, LOAD and SEND.
REQ-018 In SEL, selection SHALL search round-robin from pointer ptr for the first non-empty buffer; obfN_rd_en SHALL be high combinationally for that buffer only; next state SHALL be LOAD, else SEL.
REQ-019 At most one rd_en SHALL be high in any cycle; rd_en SHALL never be high for an empty buffer or outside SEL.
REQ-020 LOAD SHALL register out_data from the selected obfN_out, set out_ch=N and ptr=(N+1) mod 3, and go to SEND.
REQ-021 RELU_EN=1: a negative result SHALL become 0; RELU_EN=0: passed unchanged; no width change.
REQ-022 out_valid SHALL be high exactly in SEND; out_data and out_ch SHALL hold stable there.
REQ-023 SEND with out_ready=1 SHALL count the transfer and return to SEL; with out_ready=0 it SHALL remain in SEND.
REQ-024 Transfer counter SHALL be ceil(log2(OUT_NUM+1)) bits; on the transfer at count OUT_NUM-1, frame_done SHALL pulse in that cycle and the counter SHALL clear to 0.
REQ-025 Peak throughput SHALL be one result per 3 cycles.
REQ-026 err_any SHALL set on any obfN_err=1 at a clock edge and hold until reset.
REQ-027 A buffer going empty while results are pending elsewhere SHALL be skipped without a stall cycle.

Reset
REQ-028 rst_n low SHALL asynchronously force state=SEL, ptr=0, counter=0, out_data=0, out_ch=0, out_valid=0, frame_done=0, err_any=0, all rd_en=0.
REQ-029 Reset mid-transfer SHALL discard the held result; counting SHALL restart at 0 after release.

Structure
REQ-030 Package collector_pkg SHALL hold DATA_WIDTH default, NUM_CH=3 and FSM state encoding.
REQ-031 Round-robin selection SHALL be a sub-module rr_arb3: inputs request[2:0] and ptr, outputs grant one-hot and found.

Verification
REQ-032 Only obf1 non-empty, value 16'h0123, out_ready=1 -> obf1_rd_en for one cycle, out_valid two cycles later, out_data=16'h0123, out_ch=1.
REQ-033 All three non-empty with values 5, 6, 7 -> outputs in order ch0, ch1, ch2, 3-cycle spacing; ptr then 0.
REQ-034 RELU_EN=1, obf0_out=16'hFFF0 -> out_data=0; RELU_EN=0 -> 16'hFFF0.
REQ-035 out_ready=0 for 10 cycles in SEND -> out_valid and out_data held, no rd_en pulses; one transfer counted after release.
REQ-036 OUT_NUM=27, 9 results per buffer -> frame_done pulses once with the 27th transfer; counter 0 afterwards.
REQ-037 obf2_err pulse for one cycle, then rst_n low mid-SEND -> err_any=1 until reset; every output at its reset value immediately on rst_n low.
